// File: rtl/load_ext_unit_pkg.sv
// Shared memory-stage constants: store/load kind selectors, load exception
// codes and the load unit state encoding.
package load_ext_unit_pkg;

  // Store kinds used by the write-side byte-enable path
  localparam logic [1:0] MEM_STORE_WORD = 2'd0;
  localparam logic [1:0] MEM_STORE_HALF = 2'd1;
  localparam logic [1:0] MEM_STORE_BYTE = 2'd2;

  // Load kinds; encodings 5..7 are illegal
  localparam logic [2:0] MEM_LOAD_WORD  = 3'd0;
  localparam logic [2:0] MEM_LOAD_HALF  = 3'd1;
  localparam logic [2:0] MEM_LOAD_HALFU = 3'd2;
  localparam logic [2:0] MEM_LOAD_BYTE  = 3'd3;
  localparam logic [2:0] MEM_LOAD_BYTEU = 3'd4;

  // Load exception codes reported with the response
  localparam logic [1:0] LOAD_EXC_NONE    = 2'd0;
  localparam logic [1:0] LOAD_EXC_ADEL    = 2'd1;
  localparam logic [1:0] LOAD_EXC_TIMEOUT = 2'd2;
  localparam logic [1:0] LOAD_EXC_SEL     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_RESP = 2'd2
  } load_state_t;

  // True when the load kind is one of the defined encodings
  function automatic logic load_sel_legal(input logic [2:0] sel);
    return sel <= MEM_LOAD_BYTEU;
  endfunction

  // True when the address violates the natural alignment of the load kind
  function automatic logic load_misaligned(input logic [2:0] sel, input logic [1:0] a);
    logic mis;
    mis = 1'b0;
    if (sel == MEM_LOAD_WORD)
      mis = (a != 2'b00);
    else if (sel == MEM_LOAD_HALF || sel == MEM_LOAD_HALFU)
      mis = a[0];
    return mis;
  endfunction

endpackage

// File: rtl/load_ext_unit_extract.sv
// Combinational lane extraction and sign/zero extension of a read word.
module load_extract
  import load_ext_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_low,
  input  logic [2:0]  sel,
  output logic [31:0] data
);

  logic [7:0]  lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Split the read word into its four byte lanes (lane 0 = bits 7:0)
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane[gi] = rdata[8*gi+7 -: 8];
  end

  // Pick the addressed field, then extend it according to the load kind
  always_comb begin
    byte_sel = lane[addr_low];
    half_sel = addr_low[1] ? rdata[31:16] : rdata[15:0];
    data     = 32'd0;
    case (sel)
      MEM_LOAD_WORD:  data = rdata;
      MEM_LOAD_HALF:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LOAD_HALFU: data = {16'd0, half_sel};
      MEM_LOAD_BYTE:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LOAD_BYTEU: data = {24'd0, byte_sel};
      default:        data = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_ext_unit.sv
// Load unit: alignment check, word read with timeout, field extraction and
// a valid/ready response towards write-back.
module load_ext_unit
  import load_ext_unit_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_sel,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rvalid,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_data,
  output logic [1:0]        resp_exc
);

  load_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [1:0]        addr_low_reg, addr_low_next;
  logic [2:0]        sel_reg, sel_next;
  logic [7:0]        cnt_reg, cnt_next;
  logic [31:0]       data_reg, data_next;
  logic [1:0]        exc_reg, exc_next;
  logic [31:0]       ext_data;

  load_extract u_extract (
    .rdata    (mem_rdata),
    .addr_low (addr_low_reg),
    .sel      (sel_reg),
    .data     (ext_data)
  );

  // State and datapath registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      mem_addr_reg <= '0;
      addr_low_reg <= 2'd0;
      sel_reg      <= 3'd0;
      cnt_reg      <= 8'd0;
      data_reg     <= 32'd0;
      exc_reg      <= LOAD_EXC_NONE;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
      addr_low_reg <= addr_low_next;
      sel_reg      <= sel_next;
      cnt_reg      <= cnt_next;
      data_reg     <= data_next;
      exc_reg      <= exc_next;
    end
  end

  // Next-state logic; read data beats the timeout when both land together
  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    addr_low_next = addr_low_reg;
    sel_next      = sel_reg;
    cnt_next      = cnt_reg;
    data_next     = data_reg;
    exc_next      = exc_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          addr_low_next = req_addr[1:0];
          sel_next      = req_sel;
          cnt_next      = 8'd0;
          if (!load_sel_legal(req_sel)) begin
            data_next  = 32'd0;
            exc_next   = LOAD_EXC_SEL;
            state_next = ST_RESP;
          end else if (load_misaligned(req_sel, req_addr[1:0])) begin
            data_next  = 32'd0;
            exc_next   = LOAD_EXC_ADEL;
            state_next = ST_RESP;
          end else begin
            mem_addr_next = {req_addr[ADDR_W-1:2], 2'b00};
            state_next    = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (mem_rvalid) begin
          data_next  = ext_data;
          exc_next   = LOAD_EXC_NONE;
          state_next = ST_RESP;
        end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
          data_next  = 32'd0;
          exc_next   = LOAD_EXC_TIMEOUT;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          cnt_next   = 8'd0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign mem_rd_en  = (state_reg == ST_READ);
  assign mem_addr   = mem_addr_reg;
  assign resp_valid = (state_reg == ST_RESP);
  assign resp_data  = data_reg;
  assign resp_exc   = exc_reg;

endmodule

// File: tb/tb_load_ext_unit.sv
// Directed bench for load_ext_unit with a behavioural load model and scoreboard.
module tb_load_ext_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_sel;
  logic        mem_rd_en;
  logic [31:0] mem_addr, mem_rdata;
  logic        mem_rvalid;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic [1:0]  resp_exc;

  int n_checks = 0;
  int n_fail   = 0;

  // memory responder settings: delay<0 means never answer
  logic [31:0] mem_word = 32'd0;
  int          mem_delay = 0;
  int          rd_cnt = 0;
  int          rd_en_total = 0;
  logic [31:0] exp_addr = 32'd0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  load_ext_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_sel(req_sel),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_exc(resp_exc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {exc, data} of a load from the rules of the load kinds
  function automatic logic [33:0] model(input logic [31:0] word, input logic [31:0] addr,
                                        input logic [2:0] sel, input int delay);
    int a;
    int v;
    logic [31:0] sh;
    a = int'(addr % 4);
    if (sel > 3'd4) return {2'd3, 32'd0};
    if ((sel == 3'd0 && a != 0) || ((sel == 3'd1 || sel == 3'd2) && (a % 2) == 1))
      return {2'd1, 32'd0};
    if (delay < 0 || delay >= TO) return {2'd2, 32'd0};
    sh = word >> (8 * a);
    case (sel)
      3'd0: return {2'd0, word};
      3'd1: begin v = int'(sh % 65536); if (v > 32767) v = v - 65536; return {2'd0, 32'(v)}; end
      3'd2: return {2'd0, sh % 65536};
      3'd3: begin v = int'(sh % 256); if (v > 127) v = v - 256; return {2'd0, 32'(v)}; end
      default: return {2'd0, sh % 256};
    endcase
  endfunction

  // Memory: answers (delay) cycles into the read, counts strobe cycles
  always @(posedge clk) begin
    #1;
    if (mem_rd_en) begin
      mem_rvalid = (mem_delay >= 0) && (rd_cnt == mem_delay);
      mem_rdata  = mem_word;
      rd_cnt++;
      rd_en_total++;
    end else begin
      mem_rvalid = 1'b0;
      rd_cnt     = 0;
    end
  end

  // Scoreboard: every cycle compare outputs against the expected response
  always @(negedge clk) begin
    if (reset) begin
      check("req_ready_vs_busy", 32'(req_ready), 32'(!(mem_rd_en || resp_valid)));
      if (mem_rd_en) check("mem_addr", mem_addr, exp_addr);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_resp", 32'(resp_valid), 32'd0);
        end else begin
          check("resp_data", resp_data, exp_q[0][31:0]);
          check("resp_exc", 32'(resp_exc), 32'(exp_q[0][33:32]));
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_load(input logic [31:0] addr, input logic [2:0] sel,
                         input logic [31:0] word, input int delay, input int hold);
    logic [33:0] e;
    logic [31:0] d0;
    logic [1:0]  x0;
    int lat, exp_lat, exp_rd;
    e = model(word, addr, sel, delay);
    if (e[33:32] == 2'd1 || e[33:32] == 2'd3) begin exp_lat = 1; exp_rd = 0; end
    else if (e[33:32] == 2'd2) begin exp_lat = TO + 1; exp_rd = TO; end
    else begin exp_lat = delay + 2; exp_rd = delay + 1; end
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_sel = sel;
    mem_word = word; mem_delay = delay; rd_en_total = 0;
    exp_addr = {addr[31:2], 2'b00};
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; break; end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (lat == 0) begin
      exp_q.delete();
      return;
    end
    check("rd_en_cycles", 32'(rd_en_total), 32'(exp_rd));
    d0 = resp_data; x0 = resp_exc;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, d0);
      check("hold_exc", 32'(resp_exc), 32'(x0));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("req_ready_after", 32'(req_ready), 32'd1);
    check("resp_valid_after", 32'(resp_valid), 32'd0);
    $display("load addr=%h sel=%0d delay=%0d -> data=%h exc=%0d lat=%0d",
             addr, sel, delay, d0, x0, lat);
  endtask

  logic [33:0] pin;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_sel = 3'd0;
    resp_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    // model pinned against hand-computed values
    pin = model(32'h80FF1234, 32'h103, 3'd3, 0); check("pin_lb",  pin[31:0], 32'hFFFFFF80);
    pin = model(32'h80FF1234, 32'h102, 3'd4, 0); check("pin_lbu", pin[31:0], 32'h000000FF);
    pin = model(32'h80FF1234, 32'h102, 3'd2, 0); check("pin_lhu", pin[31:0], 32'h000080FF);
    pin = model(32'h80FF1234, 32'h102, 3'd1, 0); check("pin_lh",  pin[31:0], 32'hFFFF80FF);
    pin = model(32'h80FF1234, 32'h003, 3'd1, 0); check("pin_adel", 32'(pin[33:32]), 32'd1);

    // reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_exc", 32'(resp_exc), 32'd0);
    reset = 1'b1;

    do_load(32'h103, 3'd3, 32'h80FF1234, 0, 0);
    do_load(32'h102, 3'd4, 32'h80FF1234, 0, 0);
    do_load(32'h102, 3'd2, 32'h80FF1234, 0, 0);
    do_load(32'h102, 3'd1, 32'h80FF1234, 2, 0);
    do_load(32'h104, 3'd0, 32'h12345678, 3, 0);
    do_load(32'h101, 3'd4, 32'hA5C37E01, 1, 0);
    do_load(32'h100, 3'd1, 32'h00017FFF, 0, 0);
    do_load(32'h101, 3'd0, 32'hDEADBEEF, 0, 0);
    do_load(32'h003, 3'd1, 32'hDEADBEEF, 0, 0);
    do_load(32'h100, 3'd5, 32'hDEADBEEF, 0, 0);
    do_load(32'h100, 3'd7, 32'hDEADBEEF, 0, 0);
    do_load(32'h200, 3'd0, 32'h55AA55AA, -1, 0);
    do_load(32'h200, 3'd0, 32'h55AA55AA, TO - 1, 0);
    do_load(32'h10C, 3'd3, 32'h7F000000, 0, 5);

    // reset pulled low while a read is outstanding
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h40; req_sel = 3'd0;
    mem_delay = -1; exp_addr = 32'h40; rd_en_total = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_rd_en_before", 32'(mem_rd_en), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_mem_rd_en", 32'(mem_rd_en), 32'd0);
    check("abort_mem_addr", mem_addr, 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_data", resp_data, 32'd0);
    check("abort_resp_exc", 32'(resp_exc), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_load(32'h10, 3'd0, 32'hCAFEF00D, 2, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_ext_unit.md
Name: load_ext_unit

Overview:
- Read-side counterpart of the store byte-enable/data-lane path in the data-memory stage of the pipelined MIPS core.
- Accepts one load request at a time from the MEM stage and checks alignment.
- Issues a word read to a variable-latency data memory, then extracts the addressed byte or half and sign- or zero-extends it.
- Returns the result to the WB stage with a valid/ready handshake, and raises an exception code on misalignment or memory timeout.

Parameters:
- TIMEOUT, 16, max cycles from mem_rd_en to mem_rvalid before a bus-error response (2..255).
- ADDR_W, 32, byte address width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  load request present.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_W  byte address.
- req_sel  input  3  load kind: MEM_LOAD_WORD=0, MEM_LOAD_HALF=1, MEM_LOAD_HALFU=2, MEM_LOAD_BYTE=3, MEM_LOAD_BYTEU=4; others illegal.
- mem_rd_en  output  1  read strobe, held until mem_rvalid.
- mem_addr  output  ADDR_W  word-aligned address ({req_addr[ADDR_W-1:2],2'b00}).
- mem_rdata  input  32  read word, valid with mem_rvalid.
- mem_rvalid  input  1  read data valid.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  32  extended load data.
- resp_exc  output  2  0=none, 1=address error (AdEL), 2=bus timeout, 3=illegal sel.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; req_ready=1; mem_rd_en=0; mem_addr=0; resp_valid=0; resp_data=0; resp_exc=0; timeout counter=0.
- FSM states: IDLE, READ, RESP.
- IDLE, req_ready=1. On req_valid:
  - Latch addr low bits and sel.
  - Misaligned (word with addr[1:0]!=0, half with addr[0]=1) -> RESP with resp_exc=1, resp_data=0, no memory access.
  - Illegal sel -> RESP with exc=3, resp_data=0.
  - Otherwise -> READ; mem_rd_en=1 and mem_addr registered on the same edge.
- READ, req_ready=0: mem_rd_en held high, mem_addr stable. Counter increments each cycle.
  - mem_rvalid=1 -> extract, register resp_data, resp_exc=0 -> RESP. Minimum latency req accept to resp_valid is 2 cycles when mem_rvalid arrives the first READ cycle.
  - Counter reaches TIMEOUT-1 without mem_rvalid -> RESP with exc=2, resp_data=0.
  - mem_rvalid and timeout in the same cycle: data wins, exc=0.
  - mem_rd_en drops on leaving READ.
- RESP: resp_valid=1, data/exc stable until resp_ready.
  - On resp_ready -> IDLE; counter clears.
  - No new request is accepted in the same cycle; req_ready rises the next cycle.
- Extraction (addr low bits a):
  - Word: rdata as-is.
  - Half: a[1]=1 takes rdata[31:16], else rdata[15:0].
  - Byte: rdata[8*a+7 : 8*a].
  - Signed variants replicate the top bit of the field; unsigned variants zero-fill.
- mem_rvalid outside READ is ignored.
- Reset asserted mid-READ aborts the access immediately; no response is produced for the aborted request.

Decomposition:
- Load-kind selector constants (MEM_LOAD_*) and the exception codes go in the shared constants header next to the MEM_STORE_* codes.
- One natural combinational sub-module: load_extract (inputs rdata, addr_low, sel; output 32-bit extended data). It mirrors the store byte-lane logic and is unit-testable alone.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF1234, mem_rvalid one cycle after mem_rd_en -> mem_addr=0x100, resp_data=0xFFFFFF80, exc=0; resp_valid 2 cycles after accept.
- LBU and LHU at addr 0x102, mem_rdata=0x80FF1234 -> LBU gives 0x000000FF; LHU gives 0x000080FF; LH at the same addr gives 0xFFFF80FF.
- LW at 0x101, and LH at 0x003 -> resp_exc=1, resp_data=0, mem_rd_en never asserted; response one cycle after accept.
- LW at 0x200 with mem_rvalid never asserted, TIMEOUT=16 -> mem_rd_en high exactly 16 cycles, then resp_exc=2; mem_rvalid on the final cycle instead -> exc=0 with the data.
- resp_ready held low 5 cycles -> resp_valid, resp_data and resp_exc stable, req_ready=0; the cycle after the handshake req_ready=1.
- reset pulled low mid-READ -> all outputs at reset values immediately; a subsequent LW at 0x10 completes normally.
